mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mips_pkg.sv | 19 +
 rtl/mem_arb_watchdog.sv | 43 ++++
 rtl/mem_port_arbiter.sv | 227 ++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg
// Shared pipeline package. Holds the state encoding of the memory port
// arbiter FSM and the default watchdog limit used when the optional
// grant timeout (MEM_ARB_TIMEOUT_EN) is compiled in.
package mips_pkg;

    // Arbiter FSM states: idle/arbitrate, fetch granted, data granted,
    // response (ack pulse) cycle.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_IF = 2'd1,
        GNT_D  = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    // Default number of grant cycles allowed before the watchdog fires.
    localparam int MEM_ARB_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mem_arb_watchdog.sv
// mem_arb_watchdog
// Counts consecutive cycles a memory grant has been outstanding and flags
// expiry on the TIMEOUT-th cycle, so the arbiter can abandon the access at
// the end of that cycle.
//
// Ports:
//   clk     in   clock, rising edge
//   reset   in   asynchronous active-low reset
//   enable  in   a grant is outstanding this cycle; counting advances
//   clear   in   return the count to zero (grant finished or not started)
//   expire  out  this is the TIMEOUT-th consecutive grant cycle
module mem_arb_watchdog
    import mips_pkg::*;
#(
    parameter int TIMEOUT = MEM_ARB_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count;

    // The count equals the number of grant cycles already elapsed, so the
    // TIMEOUT-th cycle is the one where it reads TIMEOUT-1.
    assign expire = enable && (count == CNT_W'(TIMEOUT - 1));

    // Cycle counter; holds once expired so it cannot wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expire) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Arbitrates an instruction-fetch port and a data port onto one shared
// single-port memory. Data normally wins, but after a completed data grant a
// pending fetch goes first, so a data port that never lets go cannot starve
// fetch. Every output is registered. Each transaction takes an arbitration
// cycle, one or more grant cycles, and a single response cycle in which the
// requester's ack pulses.
//
// Optional build macro MEM_ARB_TIMEOUT_EN: adds a watchdog that ends a grant
// after TIMEOUT cycles without mem_ack, answering with err=1. Without it
// grants wait indefinitely and if_err/d_err are constant 0.
//
// Ports:
//   clk, reset                     clock; asynchronous active-low reset
//   if_req, if_addr                fetch request and address
//   if_rdata, if_ack, if_err       fetch read data, done pulse, error flag
//   d_req, d_we, d_addr, d_wdata   data request, write enable, addr, data
//   d_rdata, d_ack, d_err          data read data, done pulse, error flag
//   mem_req, mem_we, mem_addr,     shared memory request side
//   mem_wdata
//   mem_rdata, mem_ack             shared memory response side
module mem_port_arbiter
    import mips_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = MEM_ARB_TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              if_err,
    output logic              d_err
);

    arb_state_t state, state_next;

    // Set when the most recently completed grant belonged to the data port.
    logic last_d, last_d_next;

    logic              mem_req_next;
    logic              mem_we_next;
    logic [ADDR_W-1:0] mem_addr_next;
    logic [DATA_W-1:0] mem_wdata_next;
    logic              if_ack_next;
    logic              d_ack_next;
    logic [DATA_W-1:0] if_rdata_next;
    logic [DATA_W-1:0] d_rdata_next;

    logic in_grant;
    assign in_grant = (state == GNT_IF) || (state == GNT_D);

`ifdef MEM_ARB_TIMEOUT_EN
    logic expire;
    logic if_err_q, d_err_q, if_err_next, d_err_next;

    mem_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .enable (in_grant),
        .clear  (!in_grant),
        .expire (expire)
    );

    // Error flags are registered alongside the acks they qualify.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_err_q <= 1'b0;
            d_err_q  <= 1'b0;
        end else begin
            if_err_q <= if_err_next;
            d_err_q  <= d_err_next;
        end
    end

    assign if_err = if_err_q;
    assign d_err  = d_err_q;
`else
    localparam int unused_timeout = TIMEOUT;

    assign if_err = 1'b0;
    assign d_err  = 1'b0;
`endif

    // State register and last-grant memory. Reset points the last-grant bit
    // at fetch so the first arbitration after reset favours data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            last_d <= 1'b0;
        end else begin
            state  <= state_next;
            last_d <= last_d_next;
        end
    end

    // Next-state and next-output logic. Request fields are captured once at
    // grant time and held until the grant ends, so a requester changing or
    // dropping its inputs mid-grant does not disturb the memory access.
    // mem_ack is only looked at while a grant is outstanding.
    always_comb begin
        state_next     = state;
        last_d_next    = last_d;
        mem_req_next   = mem_req;
        mem_we_next    = mem_we;
        mem_addr_next  = mem_addr;
        mem_wdata_next = mem_wdata;
        if_ack_next    = 1'b0;
        d_ack_next     = 1'b0;
        if_rdata_next  = if_rdata;
        d_rdata_next   = d_rdata;
`ifdef MEM_ARB_TIMEOUT_EN
        if_err_next    = 1'b0;
        d_err_next     = 1'b0;
`endif

        case (state)
            IDLE: begin
                if (d_req && !(last_d && if_req)) begin
                    state_next     = GNT_D;
                    mem_req_next   = 1'b1;
                    mem_we_next    = d_we;
                    mem_addr_next  = d_addr;
                    mem_wdata_next = d_wdata;
                end else if (if_req) begin
                    state_next     = GNT_IF;
                    mem_req_next   = 1'b1;
                    mem_we_next    = 1'b0;
                    mem_addr_next  = if_addr;
                end
            end

            GNT_IF: begin
                if (mem_ack) begin
                    state_next    = RESP;
                    last_d_next   = 1'b0;
                    mem_req_next  = 1'b0;
                    if_ack_next   = 1'b1;
                    if_rdata_next = mem_rdata;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (expire) begin
                    state_next   = RESP;
                    last_d_next  = 1'b0;
                    mem_req_next = 1'b0;
                    if_ack_next  = 1'b1;
                    if_err_next  = 1'b1;
                end
`endif
            end

            GNT_D: begin
                if (mem_ack) begin
                    state_next   = RESP;
                    last_d_next  = 1'b1;
                    mem_req_next = 1'b0;
                    mem_we_next  = 1'b0;
                    d_ack_next   = 1'b1;
                    if (!mem_we) begin
                        d_rdata_next = mem_rdata;
                    end
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (expire) begin
                    state_next   = RESP;
                    last_d_next  = 1'b1;
                    mem_req_next = 1'b0;
                    mem_we_next  = 1'b0;
                    d_ack_next   = 1'b1;
                    d_err_next   = 1'b1;
                end
`endif
            end

            RESP: begin
                state_next = IDLE;
            end

            default: begin
                state_next   = IDLE;
                mem_req_next = 1'b0;
                mem_we_next  = 1'b0;
            end
        endcase
    end

    // Output registers; reset clears every output immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            mem_req   <= mem_req_next;
            mem_we    <= mem_we_next;
            mem_addr  <= mem_addr_next;
            mem_wdata <= mem_wdata_next;
            if_ack    <= if_ack_next;
            d_ack     <= d_ack_next;
            if_rdata  <= if_rdata_next;
            d_rdata   <= d_rdata_next;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter. Inputs change and outputs are sampled
// 1 ns after each rising edge. The memory side is driven by hand so every
// expected value below follows directly from the cycle numbering in the
// comments. The timeout section only builds with MEM_ARB_TIMEOUT_EN.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic              if_err;
    logic              d_err;

    int checks_total  = 0;
    int checks_passed = 0;

    mem_port_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ack     (d_ack),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .if_err    (if_err),
        .d_err     (d_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks_total++;
        assert (obs === expv) checks_passed++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // The two acks must never pulse together.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            check("ack_exclusive", {63'd0, if_ack & d_ack}, 64'd0);
        end
    end

    // Hard stop so a broken design can never hang the run.
    initial begin
        #100000;
        $display("[TB] FAIL sim_time_limit observed=expired expected=finished");
        $fatal(1, "[TB] time limit reached");
    end

    initial begin
        reset     = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_rdata = '0;
        mem_ack   = 1'b0;

        // Reset state.
        tick();
        tick();
        check("rst_mem_req", mem_req, 0);
        check("rst_if_ack", if_ack, 0);
        check("rst_d_ack", d_ack, 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        check("rst_if_err", if_err, 0);

        // Single fetch, memory acks two cycles after mem_req. Cycle 0 now.
        reset   = 1'b1;
        if_req  = 1'b1;
        if_addr = 32'h40;
        tick();                                   // cycle 1
        check("f_req_c1", mem_req, 1);
        check("f_addr_c1", mem_addr, 32'h40);
        check("f_we_c1", mem_we, 0);
        if_req = 1'b0;
        tick();                                   // cycle 2
        check("f_req_c2", mem_req, 1);
        check("f_addr_c2", mem_addr, 32'h40);
        check("f_ack_c2", if_ack, 0);
        tick();                                   // cycle 3
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5678;
        check("f_req_c3", mem_req, 1);
        tick();                                   // cycle 4
        mem_ack   = 1'b0;
        mem_rdata = 32'hDEAD_0000;
        check("f_ack_c4", if_ack, 1);
        check("f_rdata_c4", if_rdata, 32'h1234_5678);
        check("f_memreq_c4", mem_req, 0);
        check("f_err_c4", if_err, 0);
        tick();                                   // cycle 5, idle
        check("f_ack_c5", if_ack, 0);
        check("f_rdata_hold", if_rdata, 32'h1234_5678);

        // Stray mem_ack while idle is ignored.
        mem_ack   = 1'b1;
        mem_rdata = 32'h0000_0BAD;
        tick();
        mem_ack = 1'b0;
        check("stray_if_ack", if_ack, 0);
        check("stray_d_ack", d_ack, 0);
        check("stray_rdata", if_rdata, 32'h1234_5678);

        // Both request together, data write wins (last grant was fetch).
        if_req  = 1'b1;
        if_addr = 32'h44;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h100;
        d_wdata = 32'hCAFE;
        tick();
        check("both_req", mem_req, 1);
        check("both_we", mem_we, 1);
        check("both_addr", mem_addr, 32'h100);
        check("both_wdata", mem_wdata, 32'hCAFE);
        d_req     = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h5555_5555;
        tick();                                   // response cycle
        mem_ack = 1'b0;
        check("both_d_ack", d_ack, 1);
        check("both_if_ack0", if_ack, 0);
        check("both_wr_rdata", d_rdata, 0);
        check("both_resp_req", mem_req, 0);
        tick();                                   // idle, arbitrating fetch
        check("both_idle_req", mem_req, 0);
        tick();
        check("both_f_req", mem_req, 1);
        check("both_f_we", mem_we, 0);
        check("both_f_addr", mem_addr, 32'h44);
        if_req    = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'hA5A5_A5A5;
        tick();
        mem_ack = 1'b0;
        check("both_f_ack", if_ack, 1);
        check("both_f_rdata", if_rdata, 32'hA5A5_A5A5);
        check("both_f_dack0", d_ack, 0);
        tick();                                   // idle

        // Continuous data requests alternate with a pending fetch.
        d_req     = 1'b1;
        d_we      = 1'b0;
        d_addr    = 32'h200;
        if_req    = 1'b1;
        if_addr   = 32'h48;
        mem_ack   = 1'b1;
        mem_rdata = 32'h1111;
        tick();                                   // data grant
        check("alt1_addr", mem_addr, 32'h200);
        tick();
        check("alt1_d_ack", d_ack, 1);
        check("alt1_d_rdata", d_rdata, 32'h1111);
        mem_rdata = 32'h2222;
        tick();                                   // idle
        tick();                                   // fetch grant
        check("alt2_addr", mem_addr, 32'h48);
        check("alt2_we", mem_we, 0);
        tick();
        check("alt2_if_ack", if_ack, 1);
        check("alt2_if_rdata", if_rdata, 32'h2222);
        mem_ack = 1'b0;
        if_req  = 1'b0;
        tick();                                   // idle
        tick();                                   // data grant again
        check("alt3_req", mem_req, 1);
        check("alt3_addr", mem_addr, 32'h200);
        tick();
        check("alt3_hold", mem_req, 1);

        // Reset in the middle of a data grant.
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_req", mem_req, 0);
        check("mid_rst_dack", d_ack, 0);
        check("mid_rst_drdata", d_rdata, 0);
        tick();
        check("mid_rst_dack2", d_ack, 0);
        reset = 1'b1;
        tick();
        check("post_rst_req", mem_req, 1);
        check("post_rst_addr", mem_addr, 32'h200);
        d_req     = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h3333;
        tick();
        mem_ack = 1'b0;
        check("post_rst_dack", d_ack, 1);
        check("post_rst_drdata", d_rdata, 32'h3333);
        tick();

        // Fetch requester drops its request right after being granted.
        if_req  = 1'b1;
        if_addr = 32'h80;
        tick();
        check("drop_req", mem_req, 1);
        check("drop_addr", mem_addr, 32'h80);
        if_req = 1'b0;
        tick();
        check("drop_hold", mem_req, 1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h7777;
        tick();
        mem_ack = 1'b0;
        check("drop_ack", if_ack, 1);
        check("drop_rdata", if_rdata, 32'h7777);
        tick();
        check("drop_ack_once", if_ack, 0);
        check("drop_req_low", mem_req, 0);

        // A data write leaves d_rdata untouched.
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h104;
        d_wdata = 32'hBEEF;
        tick();
        check("wr_we", mem_we, 1);
        check("wr_wdata", mem_wdata, 32'hBEEF);
        d_req     = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h9999;
        tick();
        mem_ack = 1'b0;
        check("wr_d_ack", d_ack, 1);
        check("wr_d_rdata", d_rdata, 32'h3333);
        check("wr_d_err", d_err, 0);
        tick();

`ifdef MEM_ARB_TIMEOUT_EN
        // Memory never acks: grant ends after 8 cycles with an error ack.
        if_req  = 1'b1;
        if_addr = 32'h90;
        tick();                                   // grant cycle 1
        if_req = 1'b0;
        check("to_req_1", mem_req, 1);
        for (int i = 2; i <= 8; i++) begin
            tick();
            check("to_req_held", mem_req, 1);
            check("to_no_ack", if_ack, 0);
        end
        tick();
        check("to_req_drop", mem_req, 0);
        check("to_if_ack", if_ack, 1);
        check("to_if_err", if_err, 1);
        check("to_rdata", if_rdata, 32'h7777);
        tick();
        check("to_ack_once", if_ack, 0);
        check("to_err_clear", if_err, 0);
`endif

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
